mul_div_unit: RTL and testbench

- Parametrised, multi-cycle arithmetic unit that executes the RV32M multiply/divide group (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) on n-bit operands.
- Sits beside the combinational ALU in the execute stage. The core stalls while the unit reports busy.
- Uses an iterative shift-add multiplier and a restoring divider, one bit per cycle, with a start/busy/done handshake and a synchronous flush.

---
 rtl/mul_div_unit.sv | 214 +++++++++++++++++++++
 tb/tb_mul_div_unit.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// -----------------------------------------------------------------------------
// mul_div_unit
//
// Multi-cycle RV32M multiply/divide unit for the execute stage. The core stalls
// while busy is high. Multiplication is an iterative shift-add over a 2n-bit
// accumulator; division is restoring, one quotient bit per cycle. Both work
// on operand magnitudes, and the sign is applied when the result is formed.
//
// Ports
//   clk     in   system clock, rising edge
//   rst     in   asynchronous active-low reset
//   start   in   request, sampled only while idle
//   op      in   funct3: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
//   A, B    in   rs1 / rs2 operands, latched when start is accepted
//   flush   in   synchronous abort; wins over start
//   busy    out  high while an operation is in flight (CALC and DONE)
//   done    out  one-cycle pulse, result and dz valid
//   result  out  final value, held until the next completed operation
//   dz      out  divide-by-zero flag, updated only with done
// -----------------------------------------------------------------------------
module mul_div_unit #(
  parameter int n = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [2:0]   op,
  input  logic [n-1:0] A,
  input  logic [n-1:0] B,
  input  logic         flush,
  output logic         busy,
  output logic         done,
  output logic [n-1:0] result,
  output logic         dz
);

  localparam int CW = $clog2(n);
  localparam logic [CW-1:0] LAST_CNT = CW'(n - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Conditional two's-complement negation, operand width.
  function automatic logic [n-1:0] f_cneg(input logic [n-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  // Conditional two's-complement negation, double width (full product).
  function automatic logic [2*n-1:0] f_cneg2(input logic [2*n-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  state_t          r_state;
  logic [2:0]      r_op;
  logic [CW-1:0]   r_cnt;
  logic            r_fin;     // all n iterations have been applied
  logic [n-1:0]    r_hi;      // multiply: upper accumulator / divide: remainder
  logic [n-1:0]    r_lo;      // multiply: multiplier bits  / divide: quotient
  logic [n-1:0]    r_opb;     // multiply: |A| multiplicand / divide: |B| divisor
  logic            r_negq;    // sign of product / quotient
  logic            r_negr;    // sign of remainder (follows A)
  logic            r_busy;
  logic            r_done;
  logic [n-1:0]    r_result;
  logic            r_dz;

  // Operand decode at accept time
  logic            w_a_signed;
  logic            w_b_signed;
  logic            w_sa;
  logic            w_sb;
  logic [n-1:0]    w_amag;
  logic [n-1:0]    w_bmag;
  logic            w_bzero;
  logic            w_ovf;
  logic            w_special;
  logic [n-1:0]    w_spec_res;

  // Iteration datapath
  logic [n:0]      w_add;
  logic [n:0]      w_shr;
  logic            w_ge;
  logic [n-1:0]    w_diff;

  // Result formation
  logic [2*n-1:0]  w_prod;
  logic [n-1:0]    w_quot;
  logic [n-1:0]    w_rem;
  logic [n-1:0]    w_final;

  // A is signed for MUL/MULH/MULHSU/DIV/REM, B for MUL/MULH/DIV/REM.
  assign w_a_signed = (op != 3'b011) && (op != 3'b101) && (op != 3'b111);
  assign w_b_signed = (op == 3'b000) || (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
  assign w_sa       = w_a_signed & A[n-1];
  assign w_sb       = w_b_signed & B[n-1];
  assign w_amag     = f_cneg(A, w_sa);
  assign w_bmag     = f_cneg(B, w_sb);

  // Division cases resolved without iterating: divide by zero, and the
  // signed overflow most-negative / -1.
  assign w_bzero    = (B == '0);
  assign w_ovf      = ~op[0] && (A == {1'b1, {(n-1){1'b0}}}) && (B == '1);
  assign w_special  = op[2] && (w_bzero || w_ovf);
  assign w_spec_res = w_bzero ? (op[1] ? A : '1)
                              : (op[1] ? '0 : A);

  // Shift-add step: conditionally add the multiplicand into the upper half;
  // the carry is kept in w_add[n] and shifted down with the rest.
  assign w_add  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opb} : {(n+1){1'b0}});

  // Restoring step: shifted partial remainder needs n+1 bits because the
  // divisor may use the full unsigned range. When w_ge holds the true
  // difference is below the divisor, so n bits are enough for it.
  assign w_shr  = {r_hi, r_lo[n-1]};
  assign w_ge   = (w_shr >= {1'b0, r_opb});
  assign w_diff = w_shr[n-1:0] - r_opb;

  assign w_prod  = f_cneg2({r_hi, r_lo}, r_negq);
  assign w_quot  = f_cneg(r_lo, r_negq);
  assign w_rem   = f_cneg(r_hi, r_negr);
  assign w_final = r_op[2] ? (r_op[1] ? w_rem : w_quot)
                           : ((r_op[1:0] == 2'b00) ? w_prod[n-1:0] : w_prod[2*n-1:n]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_op     <= '0;
      r_cnt    <= '0;
      r_fin    <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_opb    <= '0;
      r_negq   <= 1'b0;
      r_negr   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
      r_dz     <= 1'b0;
    end else begin
      case (r_state)
        // Accept: latch operands as magnitudes plus sign flags
        S_IDLE: begin
          r_done <= 1'b0;
          if (start && !flush) begin
            r_op   <= op;
            r_cnt  <= '0;
            r_fin  <= 1'b0;
            r_hi   <= '0;
            r_lo   <= op[2] ? w_amag : w_bmag;
            r_opb  <= op[2] ? w_bmag : w_amag;
            r_negq <= w_sa ^ w_sb;
            r_negr <= w_sa;
            r_busy <= 1'b1;
            if (w_special) begin
              r_state  <= S_DONE;
              r_done   <= 1'b1;
              r_result <= w_spec_res;
              r_dz     <= w_bzero;
            end else begin
              r_state  <= S_CALC;
            end
          end
        end

        // Iterate n times, then spend one cycle forming the signed result
        S_CALC: begin
          if (flush) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else if (r_fin) begin
            r_state  <= S_DONE;
            r_done   <= 1'b1;
            r_result <= w_final;
            r_dz     <= 1'b0;
          end else begin
            if (r_op[2]) begin
              r_hi <= w_ge ? w_diff : w_shr[n-1:0];
              r_lo <= {r_lo[n-2:0], w_ge};
            end else begin
              r_hi <= w_add[n:1];
              r_lo <= {w_add[0], r_lo[n-1:1]};
            end
            r_cnt <= r_cnt + CW'(1);
            if (r_cnt == LAST_CNT) begin
              r_fin <= 1'b1;
            end
          end
        end

        // Result presented for one cycle
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;
  assign dz     = r_dz;

endmodule

// File: tb/tb_mul_div_unit.sv
// -----------------------------------------------------------------------------
// tb_mul_div_unit
//
// Directed bench for mul_div_unit (n = 32). Each issued operation pushes its
// hand-computed result and dz into a queue; an independent monitor pops and
// compares whenever done pulses. Latency, busy duration, flush, ignored start
// and asynchronous reset are checked inline by the stimulus process.
// -----------------------------------------------------------------------------
module tb_mul_div_unit;

  localparam int N = 32;

  typedef struct {
    logic [N-1:0] res;
    logic         dz;
    string        nm;
  } exp_t;

  logic         clk;
  logic         rst;
  logic         start;
  logic [2:0]   op;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         flush;
  logic         busy;
  logic         done;
  logic [N-1:0] result;
  logic         dz;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  mul_div_unit #(.n(N)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .A      (A),
    .B      (B),
    .flush  (flush),
    .busy   (busy),
    .done   (done),
    .result (result),
    .dz     (dz)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic void chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", nm, got, want);
    end
  endfunction

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rst === 1'b1 && done === 1'b1) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got result=%h want no done pulse", result);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk({e.nm, "_result"}, 64'(result), 64'(e.res));
        chk({e.nm, "_dz"}, 64'(dz), 64'(e.dz));
      end
    end
  end

  // Issue one operation and wait for its done pulse. inj >= 0 raises a
  // competing start in that cycle of the operation; exp_busy >= 0 checks
  // how many cycles busy was high before done.
  task automatic do_op(input string nm, input logic [2:0] o, input logic [N-1:0] a,
                       input logic [N-1:0] b, input logic [N-1:0] eres, input logic edz,
                       input int exp_lat, input int inj, input int exp_busy);
    int   guard;
    int   lat;
    int   bcnt;
    exp_t e;
    guard = 0;
    while (busy && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    if (busy) chk({nm, "_idle_wait"}, 64'(busy), 64'(0));
    start = 1'b1; op = o; A = a; B = b;
    @(posedge clk); #1;
    start = 1'b0;
    A = $urandom; B = $urandom; op = 3'($urandom_range(0, 7));
    e.res = eres; e.dz = edz; e.nm = nm;
    q.push_back(e);
    lat = 0;
    bcnt = 0;
    while (!done && lat < 100) begin
      if (busy) bcnt++;
      if (lat == inj) begin
        start = 1'b1; op = 3'b011; A = '1; B = '1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    chk({nm, "_latency"}, 64'(lat), 64'(exp_lat));
    if (exp_busy >= 0) chk({nm, "_busy_cycles"}, 64'(bcnt), 64'(exp_busy));
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; flush = 1'b0; op = '0; A = '0; B = '0;
    #1;
    chk("reset_state", {busy, done, dz, result}, 64'(0));
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state_clocked", {busy, done, dz, result}, 64'(0));
    rst = 1'b1;
    @(posedge clk); #1;

    do_op("mul_7_m3",      3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0, 33, -1, 33);
    do_op("mulh_min_min",  3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 1'b0, 33, -1, -1);
    do_op("mulhu_ones",    3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 33, -1, -1);
    do_op("mulhsu_ones",   3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 33, -1, -1);
    do_op("mul_b_zero",    3'b000, 32'h12345678, 32'd0,        32'd0,        1'b0, 33, -1, -1);
    do_op("div_m7_2",      3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b0, 33, -1, -1);
    do_op("rem_m7_2",      3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 1'b0, 33, -1, -1);
    do_op("divu_100_7",    3'b101, 32'd100,      32'd7,        32'd14,       1'b0, 33, -1, -1);
    do_op("remu_100_7",    3'b111, 32'd100,      32'd7,        32'd2,        1'b0, 33, -1, -1);
    do_op("divu_by_zero",  3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 1'b1, 0,  -1, -1);
    chk("dz_holds_idle", 64'(dz), 64'(1));
    do_op("remu_by_zero",  3'b111, 32'd5,        32'd0,        32'd5,        1'b1, 0,  -1, -1);
    do_op("div_overflow",  3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 0,  -1, -1);
    do_op("rem_overflow",  3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1'b0, 0,  -1, -1);

    // Competing start in cycle 5 must be ignored
    do_op("mul_start_ignored", 3'b000, 32'd1234, 32'd5678, 32'd7006652, 1'b0, 33, 5, 33);

    // Flush a DIV in its tenth cycle: no done, result unchanged
    start = 1'b1; op = 3'b100; A = 32'd1000; B = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_busy_low", 64'(busy), 64'(0));
    chk("flush_result_kept", 64'(result), 64'(32'd7006652));
    do_op("divu_after_flush", 3'b101, 32'd100, 32'd7, 32'd14, 1'b0, 33, -1, 33);

    // Asynchronous reset in the middle of a multiply
    start = 1'b1; op = 3'b000; A = 32'h0000FFFF; B = 32'h0000FFFF;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("async_reset_outputs", {busy, done, dz, result}, 64'(0));
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    do_op("mul_3_4_after_reset", 3'b000, 32'd3, 32'd4, 32'd12, 1'b0, 33, -1, -1);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", 64'(q.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
